// File: rtl/multi_rate_tick_gen.sv
// rtl/multi_rate_tick_gen.sv - multi-channel runtime-programmable clock-enable generator
// Each channel divides clk (or the previous channel's wrap) and emits a tick strobe and a square wave.
module multi_rate_tick_gen #(
  parameter int CHANNELS = 3,
  parameter int CNT_W = 27,
  parameter logic [CHANNELS*CNT_W-1:0] DEFAULT_DIVS = {27'd60, 27'd100, 27'd1_000_000},
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] cascade,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq
);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CNT_W-1:0]    div [CHANNELS];
  logic [CH_W-1:0]     sh_chan;
  logic [CNT_W-1:0]    sh_div;
  logic [CHANNELS-1:0] adv;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] load;
  logic                accept;
  logic                chan_ok;

  // Cascade chain resolves combinationally in channel order within one cycle.
  always_comb begin
    logic             prev_wrap;
    logic [CNT_W-1:0] d_eff;
    prev_wrap = 1'b0;
    d_eff     = '0;
    adv       = '0;
    wrap      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      d_eff     = (div[i] == '0) ? CNT_W'(1) : div[i];
      adv[i]    = en[i] & ((i > 0 && cascade[i]) ? prev_wrap : 1'b1);
      wrap[i]   = adv[i] & (cnt[i] == d_eff - CNT_W'(1));
      prev_wrap = wrap[i];
    end
  end

  // A pending divisor lands on the target's next wrap, or at once if it is disabled.
  always_comb begin
    load = '0;
    if (state == S_PENDING) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sh_chan == CH_W'(i)) load[i] = ~en[i] | wrap[i];
      end
    end
  end

  assign chan_ok = (int'(cfg_chan) < CHANNELS);

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        accept    = cfg_valid & chan_ok;
        if (accept) state_nxt = S_PENDING;
      end
      S_PENDING: begin
        if (|load) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      sh_chan <= '0;
      sh_div  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sh_chan <= cfg_chan;
        sh_div  <= cfg_div;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        div[i] <= DEFAULT_DIVS[i*CNT_W +: CNT_W];
      end
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load[i] && !en[i]) cnt[i] <= '0;
        else if (adv[i]) cnt[i] <= wrap[i] ? '0 : cnt[i] + CNT_W'(1);
        if (load[i]) div[i] <= sh_div;
      end
      tick <= wrap;
      sq   <= sq ^ wrap;
    end
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// tb/tb_multi_rate_tick_gen.sv - self-checking bench for multi_rate_tick_gen
// Vector table, directed corner sequences and random stimulus against a reference model.
module tb_multi_rate_tick_gen;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam logic [CH*W-1:0] DEFS = {8'd3, 8'd5, 8'd4};

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic [CH-1:0] cascade;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_chan;
  logic [W-1:0]  cfg_div;
  logic [CH-1:0] tick;
  logic [CH-1:0] sq;

  int total = 0;
  int bad   = 0;

  multi_rate_tick_gen #(
    .CHANNELS(CH),
    .CNT_W(W),
    .DEFAULT_DIVS(DEFS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cascade(cascade),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_div(cfg_div),
    .tick(tick),
    .sq(sq)
  );

  always #5 clk = ~clk;

  // Reference model: advances counted per period, outstanding write held in a queue.
  typedef struct {
    int chan;
    int div;
  } wr_t;

  int            m_div [CH];
  int            m_ph  [CH];
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_sq;
  wr_t           m_q [$];

  function automatic void model_reset();
    m_div  = '{4, 5, 3};
    m_ph   = '{0, 0, 0};
    m_tick = '0;
    m_sq   = '0;
    m_q.delete();
  endfunction

  function automatic void model_step();
    bit w [CH];
    bit prev;
    bit a;
    bit rdy;
    int d;
    int c;
    prev = 1'b0;
    rdy  = (m_q.size() == 0);
    for (int i = 0; i < CH; i++) begin
      d    = (m_div[i] < 1) ? 1 : m_div[i];
      a    = en[i] && ((i > 0 && cascade[i]) ? prev : 1'b1);
      w[i] = a && (m_ph[i] == d - 1);
      if (a) m_ph[i] = w[i] ? 0 : m_ph[i] + 1;
      prev = w[i];
    end
    if (!rdy) begin
      c = m_q[0].chan;
      if (!en[c]) begin
        m_div[c] = m_q[0].div;
        m_ph[c]  = 0;
        void'(m_q.pop_front());
      end else if (w[c]) begin
        m_div[c] = m_q[0].div;
        void'(m_q.pop_front());
      end
    end
    if (rdy && cfg_valid && (int'(cfg_chan) < CH))
      m_q.push_back('{int'(cfg_chan), int'(cfg_div)});
    for (int i = 0; i < CH; i++) begin
      m_tick[i] = w[i];
      m_sq[i]   = m_sq[i] ^ w[i];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_sq", 32'(sq), 32'(m_sq));
    chk("model_ready", 32'(cfg_ready), 32'(m_q.size() == 0));
  endtask

  task automatic do_reset();
    en        = '0;
    cascade   = '0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    rst       = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] en;
    logic [2:0] casc;
    logic       valid;
    logic [1:0] chan;
    logic [7:0] div;
    logic [2:0] e_tick;
    logic [2:0] e_sq;
    logic       e_ready;
  } vec_t;

  vec_t       tbl [$];
  vec_t       v;
  logic [2:0] held;
  logic       prev_sq;
  int         n;

  initial begin
    en        = '0;
    cascade   = '0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    rst       = 1'b1;
    #3;
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_sq", 32'(sq), 32'd0);
    chk("reset_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Defaults with cascade; a write to ch2 at edge 83 stays pending into the reset test.
    for (int k = 1; k <= 84; k++) begin
      v.en      = 3'b111;
      v.casc    = 3'b110;
      v.valid   = (k == 83);
      v.chan    = 2'd2;
      v.div     = 8'd9;
      v.e_tick  = {k % 60 == 0, k % 20 == 0, k % 4 == 0};
      v.e_sq    = {(k / 60) % 2 == 1, (k / 20) % 2 == 1, (k / 4) % 2 == 1};
      v.e_ready = (k < 83);
      tbl.push_back(v);
    end
    foreach (tbl[i]) begin
      en        = tbl[i].en;
      cascade   = tbl[i].casc;
      cfg_valid = tbl[i].valid;
      cfg_chan  = tbl[i].chan;
      cfg_div   = tbl[i].div;
      step();
      chk("tbl_tick", 32'(tick), 32'(tbl[i].e_tick));
      chk("tbl_sq", 32'(sq), 32'(tbl[i].e_sq));
      chk("tbl_ready", 32'(cfg_ready), 32'(tbl[i].e_ready));
    end
    cfg_valid = 1'b0;

    // Asynchronous reset between edges while pending.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_sq", 32'(sq), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (k % 60 == 0) chk("arst_resume", 32'(tick), 32'd7);
    end

    // Live reconfiguration of ch0 at count 1.
    do_reset();
    en      = 3'b111;
    cascade = 3'b110;
    step();
    cfg_valid = 1'b1;
    cfg_chan  = 2'd0;
    cfg_div   = 8'd10;
    step();
    chk("live_ready_e2", 32'(cfg_ready), 32'd0);
    cfg_chan = 2'd1;
    cfg_div  = 8'd2;
    step();
    chk("live_ready_e3", 32'(cfg_ready), 32'd0);
    step();
    chk("live_tick_e4", 32'(tick[0]), 32'd1);
    chk("live_ready_e4", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    for (int k = 5; k <= 24; k++) begin
      step();
      chk("live_tick0", 32'(tick[0]), 32'(k == 14 || k == 24));
    end

    // Degenerate divisors 1 and 0 on ch0.
    for (int j = 0; j < 2; j++) begin
      cfg_valid = 1'b1;
      cfg_chan  = 2'd0;
      cfg_div   = (j == 0) ? 8'd1 : 8'd0;
      step();
      cfg_valid = 1'b0;
      n = 0;
      while (!cfg_ready && n < 30) begin
        step();
        n++;
      end
      chk("deg_load", 32'(cfg_ready), 32'd1);
      prev_sq = sq[0];
      for (int k = 0; k < 4; k++) begin
        step();
        chk("deg_tick", 32'(tick[0]), 32'd1);
        chk("deg_sq", 32'(sq[0]), 32'(!prev_sq));
        prev_sq = sq[0];
      end
    end

    // Write to a disabled channel, then an out-of-range channel.
    do_reset();
    en      = 3'b111;
    cascade = 3'b000;
    repeat (3) step();
    en = 3'b101;
    step();
    cfg_valid = 1'b1;
    cfg_chan  = 2'd1;
    cfg_div   = 8'd7;
    step();
    cfg_valid = 1'b0;
    chk("dis_ready_lo", 32'(cfg_ready), 32'd0);
    step();
    chk("dis_ready_hi", 32'(cfg_ready), 32'd1);
    en = 3'b111;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("dis_tick1", 32'(tick[1]), 32'(k == 7));
    end
    cfg_valid = 1'b1;
    cfg_chan  = 2'd3;
    cfg_div   = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("badchan_ready", 32'(cfg_ready), 32'd1);
    for (int k = 9; k <= 14; k++) begin
      step();
      chk("badchan_tick1", 32'(tick[1]), 32'(k == 14));
    end

    // Enable gating mid-count with cascaded followers.
    do_reset();
    en      = 3'b111;
    cascade = 3'b110;
    repeat (6) step();
    held = sq;
    en   = 3'b110;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("gate_tick", 32'(tick), 32'd0);
      chk("gate_sq", 32'(sq), 32'(held));
    end
    en = 3'b111;
    step();
    chk("gate_resume1", 32'(tick[0]), 32'd0);
    step();
    chk("gate_resume2", 32'(tick[0]), 32'd1);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      en        = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111;
      if (k % 50 == 0) cascade = 3'($urandom);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_chan  = 2'($urandom);
      cfg_div   = 8'($urandom_range(0, 6));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
